fetch_pc_ctrl: RTL and testbench
================================

# fetch_pc_ctrl

Fetch-side program-counter controller: the consumer of the branch decision (`b_take`, `pc_src`) produced in the execute stage. It owns the PC register. It loads the reset vector from M[0] and the interrupt vector from M[1]. It applies taken-branch redirects from the forwarded register path or from the data bus (RET/RTI), and it drives the flush and hold signals that squash or freeze the front-end pipeline stages.

## Interface
Parameters:
- `ADDR_W`, 8: PC and memory address width.
- `RST_VEC_ADDR`, 8'h00: memory address holding the reset vector.
- `INT_VEC_ADDR`, 8'h01: memory address holding the interrupt vector.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `b_take`  in  1  branch taken, from the branch decision logic.
- `pc_src`  in  2  00 NORM, 01 FW (register target), 10 DataB (memory target), 11 treated as NORM.
- `fw_target`  in  ADDR_W  forwarded branch target, used when `pc_src`=FW.
- `datab_data`  in  ADDR_W  data-bus read value: vector or return address.
- `datab_valid`  in  1  `datab_data` is valid this cycle.
- `stall`  in  1  hazard stall; the PC must not advance.
- `fetch_len`  in  1  1 = the instruction currently being fetched is 2 bytes.
- `intr`  in  1  interrupt request, level-sensitive.
- `pc`  out  ADDR_W  current fetch address.
- `vec_rd_req`  out  1  request a data-bus read at `vec_rd_addr`.
- `vec_rd_addr`  out  ADDR_W  vector address for the read.
- `flush`  out  1  squash the IF/ID/EX contents; one-cycle pulse.
- `hold`  out  1  freeze the front end; high whenever `state`≠RUN.
- `int_ack`  out  1  one-cycle pulse when an interrupt is accepted.
- `int_ret_pc`  out  ADDR_W  PC to be pushed by the interrupt sequence.

## Operation
States: RST_VEC, RUN, RET_WAIT, INT_VEC.

Reset values:
- `state`=RST_VEC, `pc`=0, `flush`=0, `int_ack`=0, `int_ret_pc`=0.
- `vec_rd_req`=1 and `vec_rd_addr`=`RST_VEC_ADDR` (both are combinational from `state`).
- `hold`=1.

Transitions:
- RST_VEC: hold until `datab_valid`. Then `pc`←`datab_data` and go to RUN.
- RUN, evaluated in strict priority:
  1. `b_take` & `pc_src`=FW: `pc`←`fw_target`, `flush`=1 next cycle.
  2. `b_take` & `pc_src`=DataB & `datab_valid`: `pc`←`datab_data`, `flush`=1.
  3. `b_take` & `pc_src`=DataB & !`datab_valid`: go to RET_WAIT, `flush`=1.
  4. `stall`: `pc` is held.
  5. `intr`: `int_ret_pc`←`pc`, `int_ack`=1, `flush`=1, go to INT_VEC.
  6. Otherwise `pc`←`pc`+1+`fetch_len`.
- RET_WAIT: `b_take`, `pc_src` and `stall` are ignored. On `datab_valid`: `pc`←`datab_data`, go to RUN.
- INT_VEC: `vec_rd_req`=1, `vec_rd_addr`=`INT_VEC_ADDR`. On `datab_valid`: `pc`←`datab_data`, go to RUN.
- `intr` is ignored outside RUN.

Redirect qualification:
- A redirect requires `b_take`=1. `pc_src`=DataB with `b_take`=0 (the branch decision's default encoding) is ignored and behaves as NORM.
- A redirect overrides a simultaneous `stall` and `intr`. A held interrupt is accepted on a later RUN cycle.

Arithmetic: the PC increment is modulo 2^ADDR_W, so 8'hFF+1 = 8'h00 and 8'hFE+2 = 8'h00.

A `rst` asserted in any state, including mid-RET_WAIT or mid-INT_VEC, returns the block to the reset values. A `datab_valid` arriving in the reset cycle is discarded.

## Timing
- All state, `pc`, `flush`, `int_ack` and `int_ret_pc` are registered. `hold`, `vec_rd_req` and `vec_rd_addr` are decoded from `state`.
- Redirect latency: the new `pc` is visible one cycle after the `b_take` cycle. `flush` is high in that same cycle, for exactly one cycle.
- Vector/RET load: `pc` updates on the edge on which `datab_valid`=1. `hold` drops in the following cycle.
- Back-to-back redirects on consecutive RUN cycles are each honoured. Each produces its own one-cycle `flush`.
- Minimum reset-to-first-fetch time is 2 cycles: `datab_valid` in the first cycle after reset.

## Structure
- Shared package: the `pc_src` encodings (`PCSRC_NORM`=2'b00, `PCSRC_FW`=2'b01, `PCSRC_DATAB`=2'b10) and the state enum. The branch decision logic uses the same `pc_src` constants.
- No sub-module is needed. The next-PC mux and the FSM are in one always block pair (sequential + combinational).

## Test plan
- Reset, then `datab_valid`=1 with `datab_data`=8'h20 two cycles later → `hold`=1 and `vec_rd_addr`=8'h00 until then; next cycle `pc`=8'h20, `hold`=0.
- RUN at `pc`=8'h20 with `fetch_len` sequence 0,1,0 → `pc` goes 8'h21, 8'h23, 8'h24. Same check at `pc`=8'hFF with `fetch_len`=0 → `pc`=8'h00.
- `b_take`=1, `pc_src`=FW, `fw_target`=8'h40, with `stall`=1 and `intr`=1 in the same cycle → next cycle `pc`=8'h40 and `flush` pulses once, `int_ack`=0. The interrupt is then accepted on the next non-stalled cycle.
- `b_take`=1, `pc_src`=DataB, `datab_valid` delayed 3 cycles with `datab_data`=8'h55 → RET_WAIT with `hold`=1 for 3 cycles, then `pc`=8'h55. Separately, `pc_src`=DataB with `b_take`=0 → normal increment.
- `intr`=1 at `pc`=8'h30 → `int_ack` pulse, `int_ret_pc`=8'h30, `vec_rd_addr`=8'h01; `datab_data`=8'h80 → `pc`=8'h80.
- `rst` asserted during INT_VEC → state returns to RST_VEC, `pc`=0, `int_ack`=0, `vec_rd_addr`=8'h00.

Source files
------------

// File: rtl/fetch_pc_ctrl_pkg.sv
// Shared definitions for the fetch-side PC controller and the branch decision
// logic that drives it: pc_src encodings, controller states and redirect decode.
package fetch_pc_ctrl_pkg;

  // pc_src encodings. 2'b11 is unused and behaves as PCSRC_NORM.
  localparam logic [1:0] PCSRC_NORM  = 2'b00;
  localparam logic [1:0] PCSRC_FW    = 2'b01;
  localparam logic [1:0] PCSRC_DATAB = 2'b10;

  // Controller states.
  typedef enum logic [1:0] {
    ST_RST_VEC  = 2'd0,  // waiting for the reset vector on the data bus
    ST_RUN      = 2'd1,  // normal sequential fetch
    ST_RET_WAIT = 2'd2,  // waiting for a RET/RTI return address
    ST_INT_VEC  = 2'd3   // waiting for the interrupt vector
  } fetch_state_e;

  // Kind of redirect requested by the branch decision in the current cycle.
  typedef enum logic [1:0] {
    REDIR_NONE  = 2'd0,
    REDIR_FW    = 2'd1,
    REDIR_DATAB = 2'd2
  } redir_e;

  // A redirect needs b_take. DataB with b_take low is the branch decision's
  // default encoding, and 2'b11 is unused, so both of those decode to none.
  function automatic redir_e decode_redir(input logic b_take, input logic [1:0] pc_src);
    redir_e r;
    r = REDIR_NONE;
    if (b_take) begin
      if (pc_src == PCSRC_FW)         r = REDIR_FW;
      else if (pc_src == PCSRC_DATAB) r = REDIR_DATAB;
    end
    return r;
  endfunction

endpackage

// File: rtl/fetch_pc_ctrl.sv
// Fetch-side program-counter controller. It owns the PC, loads the reset and
// interrupt vectors from the data bus, and applies taken-branch redirects.
// It also generates the flush and hold controls for the front-end stages.
module fetch_pc_ctrl
  import fetch_pc_ctrl_pkg::*;
#(
  parameter int              ADDR_W       = 8,
  parameter logic [ADDR_W-1:0] RST_VEC_ADDR = ADDR_W'(8'h00),
  parameter logic [ADDR_W-1:0] INT_VEC_ADDR = ADDR_W'(8'h01)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              b_take,
  input  logic [1:0]        pc_src,
  input  logic [ADDR_W-1:0] fw_target,
  input  logic [ADDR_W-1:0] datab_data,
  input  logic              datab_valid,
  input  logic              stall,
  input  logic              fetch_len,
  input  logic              intr,
  output logic [ADDR_W-1:0] pc,
  output logic              vec_rd_req,
  output logic [ADDR_W-1:0] vec_rd_addr,
  output logic              flush,
  output logic              hold,
  output logic              int_ack,
  output logic [ADDR_W-1:0] int_ret_pc
);

  fetch_state_e      state, state_nx;
  logic [ADDR_W-1:0] pc_nx;
  logic [ADDR_W-1:0] int_ret_pc_nx;
  logic              flush_nx;
  logic              int_ack_nx;
  redir_e            redir;
  logic [ADDR_W-1:0] pc_seq;

  // Redirect request for this cycle; only acted on while in RUN.
  assign redir = decode_redir(b_take, pc_src);

  // Sequential next address; wraps modulo 2^ADDR_W by truncation.
  assign pc_seq = pc + (fetch_len ? ADDR_W'(2) : ADDR_W'(1));

  // State register and registered outputs; rst wins over any datab_valid.
  // NOTE: registers use non-blocking assignments so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ST_RST_VEC;
      pc         <= '0;
      flush      <= 1'b0;
      int_ack    <= 1'b0;
      int_ret_pc <= '0;
    end else begin
      state      <= state_nx;
      pc         <= pc_nx;
      flush      <= flush_nx;
      int_ack    <= int_ack_nx;
      int_ret_pc <= int_ret_pc_nx;
    end
  end

  // Next-state and next-PC selection; RUN cases are in strict priority order.
  // NOTE: every signal gets a default before the case, so no path through the
  // block leaves a value unassigned and no latch is inferred.
  always_comb begin
    state_nx      = state;
    pc_nx         = pc;
    int_ret_pc_nx = int_ret_pc;
    flush_nx      = 1'b0;
    int_ack_nx    = 1'b0;

    unique case (state)
      ST_RST_VEC, ST_RET_WAIT, ST_INT_VEC: begin
        // Waiting on the data bus. Branch, stall and interrupt are ignored here.
        if (datab_valid) begin
          pc_nx    = datab_data;
          state_nx = ST_RUN;
        end
      end

      ST_RUN: begin
        if (redir == REDIR_FW) begin
          pc_nx    = fw_target;
          flush_nx = 1'b1;
        end else if (redir == REDIR_DATAB) begin
          flush_nx = 1'b1;
          if (datab_valid) pc_nx    = datab_data;
          else             state_nx = ST_RET_WAIT;
        end else if (stall) begin
          pc_nx = pc;
        end else if (intr) begin
          // The PC being fetched is the return point of the interrupt.
          int_ret_pc_nx = pc;
          int_ack_nx    = 1'b1;
          flush_nx      = 1'b1;
          state_nx      = ST_INT_VEC;
        end else begin
          pc_nx = pc_seq;
        end
      end

      default: begin
        state_nx = ST_RST_VEC;
      end
    endcase
  end

  // Front-end controls decoded directly from the state.
  assign hold        = (state != ST_RUN);
  assign vec_rd_req  = (state == ST_RST_VEC) || (state == ST_INT_VEC);
  assign vec_rd_addr = (state == ST_INT_VEC) ? INT_VEC_ADDR : RST_VEC_ADDR;

endmodule

// File: tb/tb_fetch_pc_ctrl.sv
// Self-checking bench for fetch_pc_ctrl. A behavioural model tracks what the
// controller is waiting for and where the PC should be. Every cycle it is
// compared against all DUT outputs, first under directed and then random stimulus.
module tb_fetch_pc_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       b_take;
  logic [1:0] pc_src;
  logic [7:0] fw_target;
  logic [7:0] datab_data;
  logic       datab_valid;
  logic       stall;
  logic       fetch_len;
  logic       intr;
  logic [7:0] pc;
  logic       vec_rd_req;
  logic [7:0] vec_rd_addr;
  logic       flush;
  logic       hold;
  logic       int_ack;
  logic [7:0] int_ret_pc;

  always #5 clk = ~clk;

  fetch_pc_ctrl dut (
    .clk         (clk),
    .rst         (rst),
    .b_take      (b_take),
    .pc_src      (pc_src),
    .fw_target   (fw_target),
    .datab_data  (datab_data),
    .datab_valid (datab_valid),
    .stall       (stall),
    .fetch_len   (fetch_len),
    .intr        (intr),
    .pc          (pc),
    .vec_rd_req  (vec_rd_req),
    .vec_rd_addr (vec_rd_addr),
    .flush       (flush),
    .hold        (hold),
    .int_ack     (int_ack),
    .int_ret_pc  (int_ret_pc)
  );

  int checks   = 0;
  int failures = 0;

  // Model: what the controller is waiting for, plus its visible registers.
  localparam int W_BOOT = 0;  // reset vector
  localparam int W_NONE = 1;  // nothing, fetching
  localparam int W_RET  = 2;  // return address
  localparam int W_IVEC = 3;  // interrupt vector
  int         m_wait  = W_BOOT;
  int         m_pc    = 0;
  int         m_ret   = 0;
  bit         m_flush = 0;
  bit         m_ack   = 0;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Apply the controller's rules to the inputs present before the edge.
  task automatic model_step();
    m_flush = 0;
    m_ack   = 0;
    if (rst) begin
      m_wait = W_BOOT;
      m_pc   = 0;
      m_ret  = 0;
    end else if (m_wait != W_NONE) begin
      if (datab_valid) begin
        m_pc   = int'(datab_data);
        m_wait = W_NONE;
      end
    end else if (b_take && pc_src == 2'd1) begin
      m_pc    = int'(fw_target);
      m_flush = 1;
    end else if (b_take && pc_src == 2'd2) begin
      m_flush = 1;
      if (datab_valid) m_pc = int'(datab_data);
      else             m_wait = W_RET;
    end else if (stall) begin
      // PC held
    end else if (intr) begin
      m_ret   = m_pc;
      m_ack   = 1;
      m_flush = 1;
      m_wait  = W_IVEC;
    end else begin
      m_pc = (m_pc + 1 + int'(fetch_len)) % 256;
    end
  endtask

  // One clock: update the model, then compare every output after the edge.
  task automatic tick(input string tag);
    model_step();
    @(posedge clk);
    #1;
    chk({tag, ".pc"},          pc,          8'(m_pc));
    chk({tag, ".flush"},       8'(flush),   8'(m_flush));
    chk({tag, ".int_ack"},     8'(int_ack), 8'(m_ack));
    chk({tag, ".int_ret_pc"},  int_ret_pc,  8'(m_ret));
    chk({tag, ".hold"},        8'(hold),    8'(m_wait != W_NONE));
    chk({tag, ".vec_rd_req"},  8'(vec_rd_req),
        8'(m_wait == W_BOOT || m_wait == W_IVEC));
    chk({tag, ".vec_rd_addr"}, vec_rd_addr, (m_wait == W_IVEC) ? 8'h01 : 8'h00);
  endtask

  task automatic drive(input logic r, input logic bt, input logic [1:0] src,
                       input logic [7:0] fw, input logic [7:0] dd, input logic dv,
                       input logic st, input logic fl, input logic ir);
    rst = r; b_take = bt; pc_src = src; fw_target = fw;
    datab_data = dd; datab_valid = dv; stall = st; fetch_len = fl; intr = ir;
  endtask

  initial begin
    drive(1, 0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 0);

    // Reset, including a datab_valid in the reset cycle that must be dropped.
    tick("reset0");
    drive(1, 0, 2'd0, 8'h00, 8'h77, 1, 0, 0, 0);
    tick("reset_dv");

    // Boot: reset vector arrives two cycles after reset is released.
    drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 0);
    tick("boot_wait0");
    tick("boot_wait1");
    drive(0, 0, 2'd0, 8'h00, 8'h20, 1, 0, 0, 0);
    tick("boot_load");

    // Sequential fetch with lengths 0,1,0: 21, 23, 24.
    drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 0);
    tick("seq_len0");
    fetch_len = 1; tick("seq_len1");
    fetch_len = 0; tick("seq_len0b");

    // Wraparound at FF+1 and FE+2.
    drive(0, 1, 2'd1, 8'hFF, 8'h00, 0, 0, 0, 0); tick("fw_ff");
    drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 0); tick("wrap_ff");
    drive(0, 1, 2'd1, 8'hFE, 8'h00, 0, 0, 0, 0); tick("fw_fe");
    drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 0, 1, 0); tick("wrap_fe");

    // FW redirect beats simultaneous stall and intr; the interrupt waits
    // through a stall and is then accepted.
    drive(0, 1, 2'd1, 8'h40, 8'h00, 0, 1, 0, 1); tick("fw_over_stall_intr");
    drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 1, 0, 1); tick("intr_stalled");
    drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 1); tick("intr_accept40");
    drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 0); tick("ivec_wait");
    drive(0, 0, 2'd0, 8'h00, 8'h80, 1, 0, 0, 0); tick("ivec_load");

    // Interrupt at pc=30 with vector 80.
    drive(0, 1, 2'd1, 8'h30, 8'h00, 0, 0, 0, 0); tick("fw_30");
    drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 1); tick("intr_at30");
    drive(0, 0, 2'd0, 8'h00, 8'h80, 1, 0, 0, 1); tick("ivec80");

    // DataB redirect with the return address three cycles late; inputs that
    // would matter in RUN are ignored while waiting.
    drive(0, 1, 2'd2, 8'h00, 8'h00, 0, 0, 0, 0); tick("ret_start");
    drive(0, 1, 2'd1, 8'h99, 8'h00, 0, 1, 0, 1); tick("ret_wait1");
    drive(0, 1, 2'd2, 8'h00, 8'h00, 0, 0, 0, 1); tick("ret_wait2");
    drive(0, 0, 2'd0, 8'h00, 8'h55, 1, 0, 0, 0); tick("ret_load55");

    // DataB without b_take behaves as a normal increment, even with data valid.
    drive(0, 0, 2'd2, 8'h00, 8'hAA, 1, 0, 0, 0); tick("datab_no_take");

    // Immediate DataB redirect, then back-to-back FW redirects.
    drive(0, 1, 2'd2, 8'h00, 8'h66, 1, 0, 0, 0); tick("datab_now");
    drive(0, 1, 2'd1, 8'h10, 8'h00, 0, 0, 0, 0); tick("b2b_fw0");
    drive(0, 1, 2'd1, 8'h18, 8'h00, 0, 0, 0, 0); tick("b2b_fw1");
    drive(0, 1, 2'd3, 8'h77, 8'h00, 0, 0, 0, 0); tick("pcsrc_11_norm");

    // Reset in the middle of the interrupt-vector wait.
    drive(0, 0, 2'd0, 8'h00, 8'h00, 0, 0, 0, 1); tick("intr_pre_rst");
    drive(1, 0, 2'd0, 8'h00, 8'h90, 1, 0, 0, 1); tick("rst_in_ivec");
    drive(0, 0, 2'd0, 8'h00, 8'h02, 1, 0, 0, 0); tick("reboot");

    // Randomized traffic against the model.
    for (int i = 0; i < 600; i++) begin
      drive($urandom_range(63) == 0,
            $urandom_range(3) == 0,
            2'($urandom_range(3)),
            8'($urandom),
            8'($urandom),
            $urandom_range(2) == 0,
            $urandom_range(3) == 0,
            1'($urandom),
            $urandom_range(4) == 0);
      tick("rand");
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
